spi_slave_burst: RTL and testbench
==================================

// Module: spi_slave_burst
// PURPOSE
//  Next-generation SPI slave front-end. Parametrised data/address width, all four SPI modes (CPOL/CPHA),
//  slave-ID match with broadcast writes, and auto-increment burst read/write until CS_N deasserts.
//  Oversamples SCLK/CS_N/MOSI in the system clock domain. Drives an external 1-cycle-latency RAM port.
//  Sits between the board SPI pins and the slave register/RAM array; one instance per slave.
// PARAMETERS
//  MY_ID   3'd0  slave ID matched against cmd ID field; 3'd7 is reserved as broadcast
//  DATA_W  16    data word width, MSB first; legal 8..32
//  ADDR_W  8     RAM address width; legal 4..12
//  CPOL    0     SCLK idle level
//  CPHA    0     0: sample leading edge, shift trailing; 1: shift leading, sample trailing
// PORTS
//  clk          in   1       system clock; must be >= 8x SCLK
//  rst_n        in   1       asynchronous, active-low reset
//  sclk         in   1       SPI clock (asynchronous)
//  cs_n         in   1       SPI chip select, active low (asynchronous)
//  mosi         in   1       SPI data in (asynchronous)
//  miso         out  1       SPI data out
//  miso_oe      out  1       MISO output enable; high only during a selected read data phase
//  mem_we       out  1       RAM write strobe, 1-cycle pulse
//  mem_re       out  1       RAM read strobe, 1-cycle pulse; mem_rdata valid the following cycle
//  mem_addr     out  ADDR_W  RAM address (shared by read and write)
//  mem_wdata    out  DATA_W  RAM write data
//  mem_rdata    in   DATA_W  RAM read data
//  frame_done   out  1       1-cycle pulse on CS_N deassert ending a selected frame
//  frame_err    out  1       1-cycle pulse with frame_done when the frame ended mid-word
//  last_wdata   out  DATA_W  debug: last word written to RAM
// BEHAVIOUR
//  - Reset: every output 0; state S_IDLE; synchronisers preset to cs_n=1, sclk=CPOL.
//  - Sync: sclk, cs_n and mosi pass through identical 2-flop synchronisers; edges are detected on the
//    synchronised sclk, so mosi sampled on a detected sample edge is aligned.
//  - Command: CMD_W = 5+ADDR_W bits, MSB first: {id[2:0], rw (1=read), inc, addr[ADDR_W-1:0]}.
//  - States: S_IDLE -> S_CMD on cs active (bitcnt=CMD_W).
//    S_CMD: shift on sample edges; after the last bit: id mismatch (and not broadcast write) -> S_IGNORE;
//    read -> S_RD_FETCH (pulse mem_re, mem_addr=addr); write -> S_WR.
//    S_RD_FETCH: next cycle latch mem_rdata into shift_out -> S_RD.
//    S_RD: miso_oe=1; MSB driven on the first shift edge after fetch, then one bit per shift edge.
//      After the word's last sample edge: inc=1 -> addr+1, pulse mem_re, reload via S_RD_FETCH;
//      inc=0 -> S_IGNORE (miso_oe=0).
//    S_WR: shift mosi on sample edges; after DATA_W bits pulse mem_we with mem_wdata, update
//      last_wdata; inc=1 -> addr+1 and stay in S_WR; inc=0 -> S_IGNORE.
//    S_IGNORE: hold until cs inactive; no RAM access, miso_oe=0.
//  - Broadcast (id=7): writes accepted by every slave; reads with id=7 -> S_IGNORE.
//  - Address wrap: addr 2^ADDR_W-1 increments to 0.
//  - CS_N deassert in any state: -> S_IDLE next cycle; miso, miso_oe=0; a partial write word is
//    discarded (no mem_we); frame_done pulses if the ID matched; frame_err pulses if bit count is
//    mid-word (including a partial command).
//  - CS deassert and a sclk edge detected in the same cycle: CS wins, the edge is ignored.
//  - Write completion and CS deassert in the same cycle: write is committed, frame_err=0.
//  - Prefetch timing: mem_re to shift_out load is 2 clk, within one half-SCLK at the minimum clk ratio.
//  - miso returns to 0 whenever miso_oe=0.
// STRUCTURE
//  - spi_slave_pkg: state encodings, cmd field offsets, BCAST_ID=3'd7, CMD_W function of ADDR_W.
//  - Sub-module spi_edge_sync (CPOL, CPHA params): 2-flop syncs + sample_edge/shift_edge/cs_active outputs.
//  - Top holds the FSM, bit counter, shift registers and address counter.
// TESTING
//  - Mode 0, ID 0: write addr 0x12 data 0xA5C3, inc=0 -> one mem_we, addr 0x12, wdata 0xA5C3.
//  - Mode 3: read addr 0x12 with RAM=0xA5C3 -> MISO bits 1010_0101_1100_0011, miso_oe only in data phase.
//  - Burst write inc=1 from addr 0xFE, 3 words 0x1111/0x2222/0x3333 -> writes at 0xFE, 0xFF, 0x00.
//  - cmd id=2 to MY_ID=0 read -> no mem_re, miso_oe=0; id=7 write -> mem_we; id=7 read -> ignored.
//  - CS_N high after 9 data bits of a write -> no mem_we, frame_done=1 and frame_err=1 same cycle.
//  - rst_n low mid burst read -> all outputs 0 immediately; next frame decodes normally.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types and command-field layout for the burst SPI slave.
// Command word, MSB first: {id[2:0], rw, inc, addr[ADDR_W-1:0]}.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RD_FETCH,
        S_RD,
        S_WR,
        S_IGNORE
    } state_t;

    localparam logic [2:0] BCAST_ID   = 3'd7;
    localparam int         ID_W       = 3;
    localparam int         CMD_HDR_W  = 5;

    function automatic int cmd_w(input int addr_w);
        return addr_w + CMD_HDR_W;
    endfunction

    function automatic int id_lsb(input int addr_w);
        return addr_w + 2;
    endfunction

    function automatic int rw_bit(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int inc_bit(input int addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/spi_slave_burst_edge_sync.sv
// Two-flop synchronisers for the SPI pins plus mode-aware edge detection
// on the synchronised clock, so mosi_s is aligned with sample_edge.
module spi_edge_sync #(
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sample_edge,
    output logic shift_edge,
    output logic cs_active,
    output logic mosi_s
);

    // Bit order {mosi, cs_n, sclk}; presets keep the bus idle out of reset.
    localparam logic [2:0] PRESET = {1'b0, 1'b1, CPOL};

    logic [2:0] raw;
    logic [2:0] meta_reg;
    logic [2:0] sync_reg;
    logic       sclk_d_reg;
    logic       sclk_s;
    logic       rise;
    logic       fall;
    logic       lead;
    logic       trail;

    assign raw = {mosi, cs_n, sclk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg   <= PRESET;
            sync_reg   <= PRESET;
            sclk_d_reg <= CPOL;
        end else begin
            meta_reg   <= raw;
            sync_reg   <= meta_reg;
            sclk_d_reg <= sync_reg[0];
        end
    end

    assign sclk_s = sync_reg[0];
    assign rise   = sclk_s & ~sclk_d_reg;
    assign fall   = ~sclk_s & sclk_d_reg;
    assign lead   = CPOL ? fall : rise;
    assign trail  = CPOL ? rise : fall;

    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;
    assign cs_active   = ~sync_reg[1];
    assign mosi_s      = sync_reg[2];

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave front-end with ID match, broadcast writes and auto-increment
// burst access to an external RAM with one cycle of read latency.
module spi_slave_burst
    import spi_slave_pkg::*;
#(
    parameter logic [2:0] MY_ID  = 3'd0,
    parameter int         DATA_W = 16,
    parameter int         ADDR_W = 8,
    parameter bit         CPOL   = 1'b0,
    parameter bit         CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              frame_done,
    output logic              frame_err,
    output logic [DATA_W-1:0] last_wdata
);

    localparam int CMD_W = cmd_w(ADDR_W);
    localparam int SH_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] CMD_CNT  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic sample_edge;
    logic shift_edge;
    logic cs_active;
    logic mosi_s;

    spi_edge_sync #(
        .CPOL (CPOL),
        .CPHA (CPHA)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .sample_edge (sample_edge),
        .shift_edge  (shift_edge),
        .cs_active   (cs_active),
        .mosi_s      (mosi_s)
    );

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  bitcnt_reg, bitcnt_next;
    logic [SH_W-1:0]   shift_in_reg, shift_in_next;
    logic [DATA_W-1:0] shift_out_reg, shift_out_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              inc_reg, inc_next;
    logic              match_reg, match_next;
    logic              fetch_wait_reg, fetch_wait_next;
    logic              miso_reg, miso_next;
    logic              oe_reg, oe_next;
    logic              we_reg, we_next;
    logic              re_reg, re_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [DATA_W-1:0] last_wdata_reg, last_wdata_next;

    logic [SH_W-1:0]   shifted_in;
    logic [CMD_W-1:0]  cmd_word;
    logic [2:0]        cmd_id;
    logic              cmd_rw;
    logic              cmd_inc;
    logic [ADDR_W-1:0] cmd_addr;
    logic              mid_word;

    assign shifted_in = {shift_in_reg[SH_W-2:0], mosi_s};
    assign cmd_word   = shifted_in[CMD_W-1:0];
    assign cmd_id     = cmd_word[id_lsb(ADDR_W) +: ID_W];
    assign cmd_rw     = cmd_word[rw_bit(ADDR_W)];
    assign cmd_inc    = cmd_word[inc_bit(ADDR_W)];
    assign cmd_addr   = cmd_word[ADDR_W-1:0];

    // A frame is clean only if it ends on a command or data word boundary.
    assign mid_word = ((state_reg == S_CMD) && (bitcnt_reg != CMD_CNT)) ||
                      (((state_reg == S_WR) || (state_reg == S_RD)) && (bitcnt_reg != DATA_CNT));

    always_comb begin
        state_next      = state_reg;
        bitcnt_next     = bitcnt_reg;
        shift_in_next   = shift_in_reg;
        shift_out_next  = shift_out_reg;
        addr_next       = addr_reg;
        inc_next        = inc_reg;
        match_next      = match_reg;
        fetch_wait_next = fetch_wait_reg;
        miso_next       = miso_reg;
        we_next         = 1'b0;
        re_next         = 1'b0;
        mem_addr_next   = mem_addr_reg;
        wdata_next      = wdata_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        last_wdata_next = last_wdata_reg;

        if ((state_reg != S_IDLE) && !cs_active) begin
            // Chip select release overrides any edge seen in the same cycle.
            state_next = S_IDLE;
            done_next  = match_reg;
            err_next   = mid_word;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cs_active) begin
                        state_next    = S_CMD;
                        bitcnt_next   = CMD_CNT;
                        shift_in_next = '0;
                        match_next    = 1'b0;
                    end
                end
                S_CMD: begin
                    if (sample_edge) begin
                        shift_in_next = shifted_in;
                        bitcnt_next   = bitcnt_reg - ONE_CNT;
                        if (bitcnt_reg == ONE_CNT) begin
                            addr_next = cmd_addr;
                            inc_next  = cmd_inc;
                            if (cmd_rw && (cmd_id == MY_ID)) begin
                                state_next      = S_RD_FETCH;
                                match_next      = 1'b1;
                                re_next         = 1'b1;
                                mem_addr_next   = cmd_addr;
                                fetch_wait_next = 1'b1;
                            end else if (!cmd_rw && ((cmd_id == MY_ID) || (cmd_id == BCAST_ID))) begin
                                state_next  = S_WR;
                                match_next  = 1'b1;
                                bitcnt_next = DATA_CNT;
                            end else begin
                                state_next = S_IGNORE;
                            end
                        end
                    end
                end
                S_RD_FETCH: begin
                    // First cycle lets the RAM respond; the second captures its data.
                    if (fetch_wait_reg) begin
                        fetch_wait_next = 1'b0;
                    end else begin
                        shift_out_next = mem_rdata;
                        bitcnt_next    = DATA_CNT;
                        state_next     = S_RD;
                    end
                end
                S_RD: begin
                    if (shift_edge) begin
                        miso_next      = shift_out_reg[DATA_W-1];
                        shift_out_next = {shift_out_reg[DATA_W-2:0], 1'b0};
                    end
                    if (sample_edge) begin
                        bitcnt_next = bitcnt_reg - ONE_CNT;
                        if (bitcnt_reg == ONE_CNT) begin
                            if (inc_reg) begin
                                addr_next       = addr_reg + 1'b1;
                                mem_addr_next   = addr_reg + 1'b1;
                                re_next         = 1'b1;
                                fetch_wait_next = 1'b1;
                                bitcnt_next     = DATA_CNT;
                                state_next      = S_RD_FETCH;
                            end else begin
                                state_next = S_IGNORE;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (sample_edge) begin
                        shift_in_next = shifted_in;
                        bitcnt_next   = bitcnt_reg - ONE_CNT;
                        if (bitcnt_reg == ONE_CNT) begin
                            we_next         = 1'b1;
                            mem_addr_next   = addr_reg;
                            wdata_next      = shifted_in[DATA_W-1:0];
                            last_wdata_next = shifted_in[DATA_W-1:0];
                            if (inc_reg) begin
                                addr_next   = addr_reg + 1'b1;
                                bitcnt_next = DATA_CNT;
                            end else begin
                                state_next = S_IGNORE;
                            end
                        end
                    end
                end
                S_IGNORE: begin
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        oe_next = (state_next == S_RD_FETCH) || (state_next == S_RD);
        if (!oe_next) begin
            miso_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            bitcnt_reg     <= '0;
            shift_in_reg   <= '0;
            shift_out_reg  <= '0;
            addr_reg       <= '0;
            inc_reg        <= 1'b0;
            match_reg      <= 1'b0;
            fetch_wait_reg <= 1'b0;
            miso_reg       <= 1'b0;
            oe_reg         <= 1'b0;
            we_reg         <= 1'b0;
            re_reg         <= 1'b0;
            mem_addr_reg   <= '0;
            wdata_reg      <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            last_wdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            bitcnt_reg     <= bitcnt_next;
            shift_in_reg   <= shift_in_next;
            shift_out_reg  <= shift_out_next;
            addr_reg       <= addr_next;
            inc_reg        <= inc_next;
            match_reg      <= match_next;
            fetch_wait_reg <= fetch_wait_next;
            miso_reg       <= miso_next;
            oe_reg         <= oe_next;
            we_reg         <= we_next;
            re_reg         <= re_next;
            mem_addr_reg   <= mem_addr_next;
            wdata_reg      <= wdata_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            last_wdata_reg <= last_wdata_next;
        end
    end

    assign miso       = miso_reg;
    assign miso_oe    = oe_reg;
    assign mem_we     = we_reg;
    assign mem_re     = re_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = wdata_reg;
    assign frame_done = done_reg;
    assign frame_err  = err_reg;
    assign last_wdata = last_wdata_reg;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench: a mode-0 and a mode-3 slave, each with its own RAM model,
// driven by one SPI master whose pins are steered by m3_sel.
module tb_spi_slave_burst;

    localparam int H = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic m3_sel;
    logic sclk_m, cs_m, mosi_m;

    logic sclk0, cs0_n, sclk3, cs3_n;
    assign sclk0 = m3_sel ? 1'b0 : sclk_m;
    assign cs0_n = m3_sel ? 1'b1 : cs_m;
    assign sclk3 = m3_sel ? sclk_m : 1'b1;
    assign cs3_n = m3_sel ? cs_m : 1'b1;

    logic        miso0, oe0, we0, re0, done0, err0;
    logic [7:0]  addr0;
    logic [15:0] wdata0, rdata0, lw0;
    logic        miso3, oe3, we3, re3, done3, err3;
    logic [7:0]  addr3;
    logic [15:0] wdata3, rdata3, lw3;

    logic miso_m, oe_m;
    assign miso_m = m3_sel ? miso3 : miso0;
    assign oe_m   = m3_sel ? oe3 : oe0;

    spi_slave_burst #(.MY_ID(3'd0), .DATA_W(16), .ADDR_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .cs_n(cs0_n), .mosi(mosi_m),
        .miso(miso0), .miso_oe(oe0), .mem_we(we0), .mem_re(re0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_rdata(rdata0), .frame_done(done0), .frame_err(err0),
        .last_wdata(lw0)
    );

    spi_slave_burst #(.MY_ID(3'd0), .DATA_W(16), .ADDR_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk3), .cs_n(cs3_n), .mosi(mosi_m),
        .miso(miso3), .miso_oe(oe3), .mem_we(we3), .mem_re(re3), .mem_addr(addr3),
        .mem_wdata(wdata3), .mem_rdata(rdata3), .frame_done(done3), .frame_err(err3),
        .last_wdata(lw3)
    );

    logic [15:0] ram0 [0:255];
    logic [15:0] ram3 [0:255];
    always @(posedge clk) begin
        if (re0) rdata0 <= ram0[addr0];
        if (we0) ram0[addr0] <= wdata0;
        if (re3) rdata3 <= ram3[addr3];
        if (we3) ram3[addr3] <= wdata3;
    end

    // Event counters, written only by this monitor; tests compare deltas.
    int we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, oe_cyc = 0;
    int we3_cnt = 0, re3_cnt = 0, oe3_cyc = 0;
    logic [7:0]  we_addr_log [0:255];
    logic [15:0] we_data_log [0:255];
    logic [7:0]  re3_addr_log [0:255];
    always @(negedge clk) begin
        if (we0) begin
            we_addr_log[we_cnt[7:0]] = addr0;
            we_data_log[we_cnt[7:0]] = wdata0;
            we_cnt++;
        end
        if (re0) re_cnt++;
        if (done0) done_cnt++;
        if (err0) err_cnt++;
        if (done0 && err0) both_cnt++;
        if (oe0) oe_cyc++;
        if (we3) we3_cnt++;
        if (re3) begin
            re3_addr_log[re3_cnt[7:0]] = addr3;
            re3_cnt++;
        end
        if (oe3) oe3_cyc++;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic spi_frame(input int n, input logic [63:0] tx,
                             output logic [63:0] rx, output logic [63:0] oe);
        rx = '0;
        oe = '0;
        cs_m = 1'b0;
        if (!m3_sel) begin
            mosi_m = tx[n-1];
            wait_h();
            for (int i = 0; i < n; i++) begin
                sclk_m = 1'b1;
                rx = {rx[62:0], miso_m};
                oe = {oe[62:0], oe_m};
                wait_h();
                sclk_m = 1'b0;
                if (i < n - 1) mosi_m = tx[n-2-i];
                wait_h();
            end
        end else begin
            wait_h();
            for (int i = 0; i < n; i++) begin
                sclk_m = 1'b0;
                mosi_m = tx[n-1-i];
                wait_h();
                sclk_m = 1'b1;
                rx = {rx[62:0], miso_m};
                oe = {oe[62:0], oe_m};
                wait_h();
            end
        end
    endtask

    task automatic cs_release();
        wait_h();
        cs_m = 1'b1;
        mosi_m = 1'b0;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m3_sel = 1'b0;
        sclk_m = 1'b0;
        cs_m = 1'b1;
        mosi_m = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if ({miso0, oe0, we0, re0, addr0, wdata0, done0, err0, lw0} !== 45'd0) begin
            $display("FAIL reset_dut0: got %h want 0", {miso0, oe0, we0, re0, addr0, wdata0, done0, err0, lw0});
        end else n_pass++;
        n_total++;
        if ({miso3, oe3, we3, re3, addr3, wdata3, done3, err3, lw3} !== 45'd0) begin
            $display("FAIL reset_dut3: got %h want 0", {miso3, oe3, we3, re3, addr3, wdata3, done3, err3, lw3});
        end else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_write();
        logic [63:0] rx, oe;
        int bw, bd, be, bo;
        bw = we_cnt; bd = done_cnt; be = err_cnt; bo = oe_cyc;
        spi_frame(29, {35'd0, 13'h0012, 16'hA5C3}, rx, oe);
        cs_release();
        $display("mode0 write id0 addr 12 data a5c3");
        n_total++;
        if (we_cnt - bw !== 1) $display("FAIL wr_count: got %0d want 1", we_cnt - bw); else n_pass++;
        n_total++;
        if (we_addr_log[bw[7:0]] !== 8'h12) $display("FAIL wr_addr: got %h want 12", we_addr_log[bw[7:0]]); else n_pass++;
        n_total++;
        if (we_data_log[bw[7:0]] !== 16'hA5C3) $display("FAIL wr_data: got %h want a5c3", we_data_log[bw[7:0]]); else n_pass++;
        n_total++;
        if (lw0 !== 16'hA5C3) $display("FAIL last_wdata: got %h want a5c3", lw0); else n_pass++;
        n_total++;
        if (done_cnt - bd !== 1) $display("FAIL wr_done: got %0d want 1", done_cnt - bd); else n_pass++;
        n_total++;
        if (err_cnt - be !== 0) $display("FAIL wr_err: got %0d want 0", err_cnt - be); else n_pass++;
        n_total++;
        if (oe_cyc - bo !== 0) $display("FAIL wr_oe: got %0d cycles want 0", oe_cyc - bo); else n_pass++;
    endtask

    task automatic test_read_mode3();
        logic [63:0] rx, oe;
        int bw, br;
        sclk_m = 1'b1;
        m3_sel = 1'b1;
        repeat (4) @(negedge clk);
        bw = we3_cnt;
        spi_frame(29, {35'd0, 13'h0012, 16'hA5C3}, rx, oe);
        cs_release();
        $display("mode3 write addr 12 data a5c3");
        n_total++;
        if (we3_cnt - bw !== 1) $display("FAIL m3_wr_count: got %0d want 1", we3_cnt - bw); else n_pass++;
        br = re3_cnt;
        spi_frame(29, {35'd0, 13'h0212, 16'h0000}, rx, oe);
        cs_release();
        $display("mode3 read addr 12 -> %h", rx[15:0]);
        n_total++;
        if (rx[15:0] !== 16'hA5C3) $display("FAIL m3_rd_data: got %h want a5c3", rx[15:0]); else n_pass++;
        n_total++;
        if (oe !== 64'h0000_0000_0000_FFFF) $display("FAIL m3_rd_oe: got %h want ffff", oe); else n_pass++;
        n_total++;
        if (re3_cnt - br !== 1) $display("FAIL m3_re_count: got %0d want 1", re3_cnt - br); else n_pass++;
        n_total++;
        if (re3_addr_log[br[7:0]] !== 8'h12) $display("FAIL m3_re_addr: got %h want 12", re3_addr_log[br[7:0]]); else n_pass++;
        n_total++;
        if ({oe3, miso3} !== 2'b00) $display("FAIL m3_idle_pins: got %b want 00", {oe3, miso3}); else n_pass++;
        sclk_m = 1'b0;
        m3_sel = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_burst_write();
        logic [63:0] rx, oe;
        int bw, bd, be;
        bw = we_cnt; bd = done_cnt; be = err_cnt;
        spi_frame(61, {3'd0, 13'h01FE, 16'h1111, 16'h2222, 16'h3333}, rx, oe);
        cs_release();
        $display("mode0 burst write from fe, 3 words");
        n_total++;
        if (we_cnt - bw !== 3) $display("FAIL burst_count: got %0d want 3", we_cnt - bw); else n_pass++;
        n_total++;
        if (we_addr_log[bw[7:0]] !== 8'hFE) $display("FAIL burst_addr0: got %h want fe", we_addr_log[bw[7:0]]); else n_pass++;
        n_total++;
        if (we_addr_log[bw[7:0] + 8'd1] !== 8'hFF) $display("FAIL burst_addr1: got %h want ff", we_addr_log[bw[7:0] + 8'd1]); else n_pass++;
        n_total++;
        if (we_addr_log[bw[7:0] + 8'd2] !== 8'h00) $display("FAIL burst_wrap: got %h want 00", we_addr_log[bw[7:0] + 8'd2]); else n_pass++;
        n_total++;
        if ({we_data_log[bw[7:0]], we_data_log[bw[7:0] + 8'd1], we_data_log[bw[7:0] + 8'd2]} !== 48'h1111_2222_3333)
            $display("FAIL burst_data: got %h %h %h want 1111 2222 3333",
                     we_data_log[bw[7:0]], we_data_log[bw[7:0] + 8'd1], we_data_log[bw[7:0] + 8'd2]);
        else n_pass++;
        n_total++;
        if (done_cnt - bd !== 1 || err_cnt - be !== 0)
            $display("FAIL burst_frame: got done %0d err %0d want 1 0", done_cnt - bd, err_cnt - be);
        else n_pass++;
    endtask

    task automatic test_id();
        logic [63:0] rx, oe;
        int bw, br, bd, bo;
        br = re_cnt; bo = oe_cyc; bd = done_cnt;
        spi_frame(29, {35'd0, 13'h0A12, 16'h0000}, rx, oe);
        cs_release();
        $display("read with id 2 (not ours)");
        n_total++;
        if (re_cnt - br !== 0) $display("FAIL id2_re: got %0d want 0", re_cnt - br); else n_pass++;
        n_total++;
        if (oe_cyc - bo !== 0) $display("FAIL id2_oe: got %0d cycles want 0", oe_cyc - bo); else n_pass++;
        n_total++;
        if (done_cnt - bd !== 0) $display("FAIL id2_done: got %0d want 0", done_cnt - bd); else n_pass++;
        bw = we_cnt; bd = done_cnt;
        spi_frame(29, {35'd0, 13'h1C34, 16'hBEEF}, rx, oe);
        cs_release();
        $display("broadcast write addr 34 data beef");
        n_total++;
        if (we_cnt - bw !== 1) $display("FAIL bcast_wr_count: got %0d want 1", we_cnt - bw); else n_pass++;
        n_total++;
        if ({we_addr_log[bw[7:0]], we_data_log[bw[7:0]]} !== 24'h34_BEEF)
            $display("FAIL bcast_wr: got %h %h want 34 beef", we_addr_log[bw[7:0]], we_data_log[bw[7:0]]);
        else n_pass++;
        n_total++;
        if (done_cnt - bd !== 1) $display("FAIL bcast_done: got %0d want 1", done_cnt - bd); else n_pass++;
        br = re_cnt; bo = oe_cyc;
        spi_frame(29, {35'd0, 13'h1E34, 16'h0000}, rx, oe);
        cs_release();
        $display("broadcast read addr 34");
        n_total++;
        if (re_cnt - br !== 0 || oe_cyc - bo !== 0)
            $display("FAIL bcast_rd: got re %0d oe %0d want 0 0", re_cnt - br, oe_cyc - bo);
        else n_pass++;
    endtask

    task automatic test_partial();
        logic [63:0] rx, oe;
        int bw, bd, be, bb;
        bw = we_cnt; bd = done_cnt; be = err_cnt; bb = both_cnt;
        spi_frame(22, {42'd0, 13'h0020, 9'h1A5}, rx, oe);
        cs_release();
        $display("write addr 20 aborted after 9 data bits");
        n_total++;
        if (we_cnt - bw !== 0) $display("FAIL part_we: got %0d want 0", we_cnt - bw); else n_pass++;
        n_total++;
        if (done_cnt - bd !== 1) $display("FAIL part_done: got %0d want 1", done_cnt - bd); else n_pass++;
        n_total++;
        if (err_cnt - be !== 1) $display("FAIL part_err: got %0d want 1", err_cnt - be); else n_pass++;
        n_total++;
        if (both_cnt - bb !== 1) $display("FAIL part_same_cycle: got %0d want 1", both_cnt - bb); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] rx, oe;
        int bw, bd;
        bw = we_cnt;
        spi_frame(45, {19'd0, 13'h0140, 16'h1234, 16'h5678}, rx, oe);
        cs_release();
        $display("burst write addr 40: 1234 5678");
        n_total++;
        if (we_cnt - bw !== 2) $display("FAIL setup_wr: got %0d want 2", we_cnt - bw); else n_pass++;
        spi_frame(33, {31'd0, 13'h0340, 20'd0}, rx, oe);
        $display("burst read addr 40 interrupted by reset");
        n_total++;
        if (rx[19:0] !== 20'h12345) $display("FAIL midrd_data: got %h want 12345", rx[19:0]); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({miso0, oe0, we0, re0, addr0, wdata0, done0, err0, lw0} !== 45'd0)
            $display("FAIL async_reset: got %h want 0", {miso0, oe0, we0, re0, addr0, wdata0, done0, err0, lw0});
        else n_pass++;
        cs_m = 1'b1;
        sclk_m = 1'b0;
        mosi_m = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bd = done_cnt;
        spi_frame(29, {35'd0, 13'h0240, 16'h0000}, rx, oe);
        cs_release();
        $display("post-reset read addr 40 -> %h", rx[15:0]);
        n_total++;
        if (rx[15:0] !== 16'h1234) $display("FAIL post_rst_rd: got %h want 1234", rx[15:0]); else n_pass++;
        n_total++;
        if (done_cnt - bd !== 1) $display("FAIL post_rst_done: got %0d want 1", done_cnt - bd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_mode3();
        test_burst_write();
        test_id();
        test_partial();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
